cdc_handshake_clr: RTL and testbench

- Multi-bit clock-domain-crossing handshake built from async-clear flops, modelled on Xilinx xpm_cdc_handshake.
- Sits upstream of FDCE-based register banks in the destination domain.
- Source side captures a WIDTH-bit word and raises a request. The request crosses through a synchroniser chain; the destination latches the held word and returns an acknowledge through a second chain.
- Synthesisable and Verilator-compatible; no `timescale` under verilator3.

---
 rtl/cdc_hsk_pkg.sv | 31 +++
 rtl/cdc_sync_bit.sv | 27 ++
 rtl/cdc_handshake_clr.sv | 168 ++++++++++++++++
 tb/tb_cdc_handshake_clr.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_hsk_pkg.sv
// Shared definitions for the async-clear multi-bit CDC handshake.
// Holds the FSM state types and the synchroniser stage-count limits.
package cdc_hsk_pkg;

   localparam int SYNC_FF_MIN = 2;
   localparam int SYNC_FF_MAX = 10;
   localparam int WIDTH_MIN   = 1;
   localparam int WIDTH_MAX   = 1024;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_ACKED = 2'd2,
      S_DRAIN = 2'd3
   } src_state_t;

   typedef enum logic [1:0] {
      D_IDLE = 2'd0,
      D_REQ  = 2'd1,
      D_ACK  = 2'd2
   } dest_state_t;

   function automatic bit sync_ff_ok(input int n);
      return (n >= SYNC_FF_MIN) && (n <= SYNC_FF_MAX);
   endfunction

   function automatic bit width_ok(input int n);
      return (n >= WIDTH_MIN) && (n <= WIDTH_MAX);
   endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// N-stage single-bit synchroniser with asynchronous clear to 0.
// Every stage is tagged ASYNC_REG so placement keeps the chain tight.
module cdc_sync_bit #(
   parameter int STAGES = 4
) (
   input  logic clk,
   input  logic clr,
   input  logic d,
   output logic q
);

   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_reg;
   logic [STAGES-1:0] sync_next;

   assign sync_next = {sync_reg[STAGES-2:0], d};

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= sync_next;
      end
   end

   assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/cdc_handshake_clr.sv
// Multi-bit req/ack clock-domain-crossing handshake with async-clear flops.
// Define CDC_HSK_ASSERT_EN to compile in simulation-only protocol checkers.
module cdc_handshake_clr
   import cdc_hsk_pkg::*;
#(
   parameter int WIDTH           = 8,
   parameter int DEST_SYNC_FF    = 4,
   parameter int SRC_SYNC_FF     = 4,
   parameter int DEST_EXT_HSK    = 1,
   parameter bit IS_CLR_INVERTED = 1'b0
) (
   input  logic             CLR,
   input  logic             SRC_CLK,
   input  logic             DEST_CLK,
   input  logic [WIDTH-1:0] SRC_IN,
   input  logic             SRC_SEND,
   output logic             SRC_RCV,
   output logic [WIDTH-1:0] DEST_OUT,
   output logic             DEST_REQ,
   input  logic             DEST_ACK
);

   localparam bit EXT_HSK = (DEST_EXT_HSK != 0);

   generate
      if (!sync_ff_ok(DEST_SYNC_FF) || !sync_ff_ok(SRC_SYNC_FF) || !width_ok(WIDTH)) begin : g_param_err
         $error("cdc_handshake_clr: WIDTH or sync stage count out of range");
      end
   endgenerate

   logic _w_CLR;
   assign _w_CLR = CLR ^ IS_CLR_INVERTED;

   logic req_sync;
   logic ack_sync;

   src_state_t       src_state_reg, src_state_next;
   logic [WIDTH-1:0] src_hold_reg, src_hold_next;
   logic             src_req_reg, src_req_next;
   logic             src_rcv_reg, src_rcv_next;

   dest_state_t      dest_state_reg, dest_state_next;
   logic [WIDTH-1:0] dest_out_reg, dest_out_next;
   logic             dest_req_reg, dest_req_next;
   logic             dest_ack_reg, dest_ack_next;

   cdc_sync_bit #(.STAGES(DEST_SYNC_FF)) u_req_sync (
      .clk (DEST_CLK),
      .clr (_w_CLR),
      .d   (src_req_reg),
      .q   (req_sync)
   );

   cdc_sync_bit #(.STAGES(SRC_SYNC_FF)) u_ack_sync (
      .clk (SRC_CLK),
      .clr (_w_CLR),
      .d   (dest_ack_reg),
      .q   (ack_sync)
   );

   always_ff @(posedge SRC_CLK or posedge _w_CLR) begin
      if (_w_CLR) begin
         src_state_reg <= S_IDLE;
         src_hold_reg  <= '0;
         src_req_reg   <= 1'b0;
         src_rcv_reg   <= 1'b0;
      end else begin
         src_state_reg <= src_state_next;
         src_hold_reg  <= src_hold_next;
         src_req_reg   <= src_req_next;
         src_rcv_reg   <= src_rcv_next;
      end
   end

   // The hold register only loads in S_IDLE, so it is frozen whenever req can be seen.
   always_comb begin
      src_state_next = src_state_reg;
      src_hold_next  = src_hold_reg;
      src_req_next   = src_req_reg;
      src_rcv_next   = src_rcv_reg;
      case (src_state_reg)
         S_IDLE: if (SRC_SEND) begin
            src_hold_next  = SRC_IN;
            src_req_next   = 1'b1;
            src_state_next = S_REQ;
         end
         S_REQ: if (ack_sync) begin
            src_rcv_next   = 1'b1;
            src_state_next = S_ACKED;
         end
         S_ACKED: if (!SRC_SEND) begin
            src_req_next   = 1'b0;
            src_state_next = S_DRAIN;
         end
         S_DRAIN: if (!ack_sync) begin
            src_rcv_next   = 1'b0;
            src_state_next = S_IDLE;
         end
         default: src_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge DEST_CLK or posedge _w_CLR) begin
      if (_w_CLR) begin
         dest_state_reg <= D_IDLE;
         dest_out_reg   <= '0;
         dest_req_reg   <= 1'b0;
         dest_ack_reg   <= 1'b0;
      end else begin
         dest_state_reg <= dest_state_next;
         dest_out_reg   <= dest_out_next;
         dest_req_reg   <= dest_req_next;
         dest_ack_reg   <= dest_ack_next;
      end
   end

   // In D_REQ the request is already high, so an ACK seen here is always a valid one.
   always_comb begin
      dest_state_next = dest_state_reg;
      dest_out_next   = dest_out_reg;
      dest_req_next   = dest_req_reg;
      dest_ack_next   = dest_ack_reg;
      case (dest_state_reg)
         D_IDLE: if (req_sync) begin
            dest_out_next   = src_hold_reg;
            dest_req_next   = 1'b1;
            dest_state_next = D_REQ;
         end
         D_REQ: if (!EXT_HSK || DEST_ACK) begin
            dest_req_next   = 1'b0;
            dest_ack_next   = 1'b1;
            dest_state_next = D_ACK;
         end
         D_ACK: if (!req_sync) begin
            dest_ack_next   = 1'b0;
            dest_state_next = D_IDLE;
         end
         default: dest_state_next = D_IDLE;
      endcase
   end

   assign SRC_RCV  = src_rcv_reg;
   assign DEST_OUT = dest_out_reg;
   assign DEST_REQ = dest_req_reg;

`ifdef CDC_HSK_ASSERT_EN
   always @(posedge SRC_CLK) begin
      if (!_w_CLR && src_state_reg == S_REQ && !SRC_SEND) begin
         $display("%0t %m: SRC_SEND dropped before SRC_RCV", $time);
         $stop;
      end
      if (!_w_CLR && src_state_reg == S_DRAIN && SRC_SEND) begin
         $display("%0t %m: SRC_SEND raised during drain", $time);
         $stop;
      end
   end

   always @(posedge DEST_CLK) begin
      if (!_w_CLR && EXT_HSK && DEST_ACK && !dest_req_reg && dest_state_reg == D_IDLE) begin
         $display("%0t %m: DEST_ACK asserted with no pending DEST_REQ", $time);
         $stop;
      end
   end
`else
   // Protocol checkers compiled out; datapath and FSMs are unchanged.
`endif

endmodule

// File: tb/tb_cdc_handshake_clr.sv
// Bench for cdc_handshake_clr: an external-ack instance and an inverted-clear
// auto-ack instance share one source side; scoreboards check every DEST_REQ.
module tb_cdc_handshake_clr;

   typedef struct {
      logic [7:0] data;
      int         width;
      int         cap;
   } exp_t;

   typedef struct {
      logic [7:0] src_in;
      logic [7:0] src_after;
      int         ack_delay;
      logic [7:0] exp_out;
      int         exp_width;
   } vec_t;

   int src_half  = 6667;
   int dest_half = 5000;
   logic src_clk  = 1'b0;
   logic dest_clk = 1'b0;
   always #(src_half) src_clk = ~src_clk;
   always #(dest_half) dest_clk = ~dest_clk;

   logic       clr = 1'b0;
   logic       clr_n;
   logic [7:0] src_in = 8'h00;
   logic       src_send = 1'b0;
   logic       dest_ack = 1'b0;
   logic       ext_rcv, ext_req, auto_rcv, auto_req;
   logic [7:0] ext_out, auto_out;

   assign clr_n = ~clr;

   cdc_handshake_clr #(
      .WIDTH(8), .DEST_SYNC_FF(4), .SRC_SYNC_FF(4), .DEST_EXT_HSK(1), .IS_CLR_INVERTED(1'b0)
   ) u_ext (
      .CLR(clr), .SRC_CLK(src_clk), .DEST_CLK(dest_clk), .SRC_IN(src_in), .SRC_SEND(src_send),
      .SRC_RCV(ext_rcv), .DEST_OUT(ext_out), .DEST_REQ(ext_req), .DEST_ACK(dest_ack)
   );

   cdc_handshake_clr #(
      .WIDTH(8), .DEST_SYNC_FF(4), .SRC_SYNC_FF(4), .DEST_EXT_HSK(0), .IS_CLR_INVERTED(1'b1)
   ) u_auto (
      .CLR(clr_n), .SRC_CLK(src_clk), .DEST_CLK(dest_clk), .SRC_IN(src_in), .SRC_SEND(src_send),
      .SRC_RCV(auto_rcv), .DEST_OUT(auto_out), .DEST_REQ(auto_req), .DEST_ACK(dest_ack)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   exp_t q_ext[$];
   exp_t q_auto[$];
   int   dest_cnt = 0;
   logic chk_lat  = 1'b0;

   always @(posedge dest_clk) dest_cnt++;

   // Destination responder: 0 means DEST_ACK held high, else ack so DEST_REQ lasts that many cycles.
   int ack_cfg = 1;
   int ack_cnt = 0;
   always @(negedge dest_clk) begin
      if (ack_cfg == 0) begin
         dest_ack = 1'b1;
      end else if (ext_req) begin
         ack_cnt++;
         if (ack_cnt >= ack_cfg) dest_ack = 1'b1;
      end else begin
         ack_cnt  = 0;
         dest_ack = 1'b0;
      end
   end

   exp_t cur_e, cur_a;
   int   w_e = 0, w_a = 0, rises_e = 0, rises_a = 0;
   logic req_e_q = 1'b0, req_a_q = 1'b0, rcv_bad_e = 1'b0;

   always @(negedge dest_clk) begin
      if (ext_req && !req_e_q) begin
         rises_e++;
         check("ext_pending_on_req", q_ext.size() > 0, 1);
         if (q_ext.size() > 0) begin
            cur_e = q_ext.pop_front();
            check("ext_dest_out", ext_out, cur_e.data);
            if (chk_lat)
               check("ext_latency_5pm1", (dest_cnt - cur_e.cap >= 4) && (dest_cnt - cur_e.cap <= 6), 1);
         end
         w_e       = 0;
         rcv_bad_e = 1'b0;
      end
      if (ext_req) begin
         w_e++;
         if (ext_rcv) rcv_bad_e = 1'b1;
      end else if (req_e_q) begin
         check("ext_req_width", w_e, cur_e.width);
         check("ext_rcv_during_req", rcv_bad_e, 0);
      end
      req_e_q = ext_req;
   end

   always @(negedge dest_clk) begin
      if (auto_req && !req_a_q) begin
         rises_a++;
         check("auto_pending_on_req", q_auto.size() > 0, 1);
         if (q_auto.size() > 0) begin
            cur_a = q_auto.pop_front();
            check("auto_dest_out", auto_out, cur_a.data);
            if (chk_lat)
               check("auto_latency_5pm1", (dest_cnt - cur_a.cap >= 4) && (dest_cnt - cur_a.cap <= 6), 1);
         end
         w_a = 0;
      end
      if (auto_req) w_a++;
      else if (req_a_q) check("auto_req_width", w_a, cur_a.width);
      req_a_q = auto_req;
   end

   // Called at a src_clk negedge; returns at the negedge where both SRC_RCV are seen low.
   task automatic xfer(input logic [7:0] d, input logic [7:0] d_after, input int width);
      exp_t e;
      src_in   = d;
      src_send = 1'b1;
      @(posedge src_clk);
      e.data  = d;
      e.width = width;
      e.cap   = dest_cnt;
      q_ext.push_back(e);
      e.width = 1;
      q_auto.push_back(e);
      @(negedge src_clk);
      src_in = d_after;
      for (int k = 0; k < 400 && !(ext_rcv && auto_rcv); k++) @(negedge src_clk);
      check("src_rcv_high", ext_rcv && auto_rcv, 1);
      src_send = 1'b0;
      for (int k = 0; k < 400 && (ext_rcv || auto_rcv); k++) @(negedge src_clk);
      check("src_rcv_low", ext_rcv || auto_rcv, 0);
   endtask

   task automatic check_outs_zero(input string tag);
      check({tag, "_ext_rcv"}, ext_rcv, 0);
      check({tag, "_ext_req"}, ext_req, 0);
      check({tag, "_ext_out"}, ext_out, 0);
      check({tag, "_auto_rcv"}, auto_rcv, 0);
      check({tag, "_auto_req"}, auto_req, 0);
      check({tag, "_auto_out"}, auto_out, 0);
   endtask

   initial begin
      #1000000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   vec_t vecs[6];
   int   sv_e, sv_a;

   initial begin
      vecs[0] = '{8'hA5, 8'h3C, 1,  8'hA5, 1};
      vecs[1] = '{8'h3C, 8'hC3, 10, 8'h3C, 10};
      vecs[2] = '{8'hFF, 8'h00, 0,  8'hFF, 1};
      vecs[3] = '{8'h00, 8'hFF, 3,  8'h00, 3};
      vecs[4] = '{8'h01, 8'h80, 2,  8'h01, 2};
      vecs[5] = '{8'h80, 8'h7F, 5,  8'h80, 5};

      #1 clr = 1'b1;
      repeat (3) @(negedge dest_clk);
      check_outs_zero("reset");
      clr = 1'b0;
      repeat (3) @(negedge dest_clk);
      repeat (3) @(negedge src_clk);

      chk_lat = 1'b1;
      foreach (vecs[i]) begin
         ack_cfg = vecs[i].ack_delay;
         xfer(vecs[i].src_in, vecs[i].src_after, vecs[i].exp_width);
         check("tbl_ext_out_hold", ext_out, vecs[i].exp_out);
         check("tbl_auto_out_hold", auto_out, vecs[i].exp_out);
      end

      // Clear while the request sits in the second synchroniser stage.
      ack_cfg = 1;
      src_in   = 8'hC3;
      src_send = 1'b1;
      @(posedge src_clk);
      repeat (2) @(posedge dest_clk);
      #1;
      clr      = 1'b1;
      src_send = 1'b0;
      sv_e     = rises_e;
      sv_a     = rises_a;
      #1;
      check_outs_zero("midclr");
      #20000;
      clr = 1'b0;
      repeat (30) @(negedge dest_clk);
      check("midclr_no_ext_req", rises_e - sv_e, 0);
      check("midclr_no_auto_req", rises_a - sv_a, 0);
      check("midclr_ext_out", ext_out, 0);
      @(negedge src_clk);
      xfer(8'h5A, 8'h00, 1);
      check("post_clr_ext_out", ext_out, 8'h5A);
      check("post_clr_auto_out", auto_out, 8'h5A);

      // Clock-ratio sweep: back-to-back incrementing data at 100/33 then 33/100 MHz.
      chk_lat = 1'b0;
      for (int r = 0; r < 2; r++) begin
         src_half  = (r == 0) ? 5000 : 15152;
         dest_half = (r == 0) ? 15152 : 5000;
         repeat (4) @(negedge src_clk);
         for (int i = 0; i < 200; i++) begin
            logic [7:0] dv;
            int         dly;
            dv      = 8'(r * 200 + i);
            dly     = int'($urandom_range(1, 3));
            ack_cfg = dly;
            xfer(dv, ~dv, dly);
         end
      end

      repeat (20) @(negedge dest_clk);
      check("ext_queue_empty", q_ext.size(), 0);
      check("auto_queue_empty", q_auto.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
